escalonador_round_robin: RTL and testbench

Hardware round-robin process scheduler for the multiprogrammed CPU. It keeps a per-process state table and counts retired instructions against a quantum. On quantum expiry, process end or I/O block it selects the next READY process. It then requests a context switch from the CPU's save routine, handshaking on req/ack, and publishes the process id the CPU loads into its current-process register.

---
 rtl/escalonador_pkg.sv | 21 ++
 rtl/busca_proximo_pronto.sv | 23 ++
 rtl/escalonador_round_robin.sv | 136 +++++++++++++
 tb/tb_escalonador_round_robin.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/escalonador_pkg.sv
// Shared encodings for the round-robin process scheduler: process-table entry
// states, scheduler FSM states and default table geometry.
package escalonador_pkg;
  localparam int NUM_PROC_DEF = 8;
  localparam int PID_W_DEF    = 3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    READY   = 2'd1,
    BLOCKED = 2'd2,
    DONE    = 2'd3
  } ent_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    SELECT  = 3'd2,
    REQ     = 3'd3,
    WAIT_IO = 3'd4
  } st_e;
endpackage

// File: rtl/busca_proximo_pronto.sv
// Rotating priority finder: first set bit of ready at or after start, wrapping
// modulo NUM_PROC, so the entry just before start is examined last.
module busca_proximo_pronto #(
  parameter int NUM_PROC = 8,
  parameter int PID_W    = 3
) (
  input  logic [NUM_PROC-1:0] ready,
  input  logic [PID_W-1:0]    start,
  output logic                found,
  output logic [PID_W-1:0]    pid
);
  // Walk from the farthest offset down so the nearest hit overwrites the rest.
  always_comb begin
    found = 1'b0;
    pid   = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (ready[start + PID_W'(i)]) begin
        found = 1'b1;
        pid   = start + PID_W'(i);
      end
    end
  end
endmodule

// File: rtl/escalonador_round_robin.sv
// Round-robin process scheduler: per-process state table, quantum counter over
// retired instructions, and req/ack context-switch handshake with the CPU.
module escalonador_round_robin
  import escalonador_pkg::*;
#(
  parameter int NUM_PROC = NUM_PROC_DEF,
  parameter int PID_W    = PID_W_DEF,
  parameter int QUANTUM  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [PID_W:0]   cfg_count,
  input  logic             instr_retire,
  input  logic             proc_end,
  input  logic             io_block,
  input  logic             io_done,
  input  logic [PID_W-1:0] io_done_pid,
  input  logic             switch_ack,
  output logic             switch_req,
  output logic [PID_W-1:0] next_pid,
  output logic [PID_W-1:0] cur_pid,
  output logic             waiting_io,
  output logic             all_done,
  output logic             busy
);
  localparam int CW = $clog2(QUANTUM) + 1;

  st_e                  state, state_nxt;
  ent_e                 tbl [NUM_PROC];
  logic [CW-1:0]        cnt;
  logic [NUM_PROC-1:0]  ready_v, blocked_v;
  logic                 found;
  logic [PID_W-1:0]     found_pid;
  logic                 cfg_ok, expire, io_wake;

  always_comb begin
    ready_v   = '0;
    blocked_v = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      ready_v[i]   = (tbl[i] == READY);
      blocked_v[i] = (tbl[i] == BLOCKED);
    end
  end

  assign cfg_ok  = cfg_valid && (cfg_count != '0) &&
                   (cfg_count <= (PID_W+1)'(NUM_PROC));
  assign expire  = instr_retire && (cnt == CW'(QUANTUM - 1));
  assign io_wake = io_done && (tbl[io_done_pid] == BLOCKED);
  assign busy    = (state != IDLE);

  // Start one past the owner so the current process is only re-picked last.
  busca_proximo_pronto #(.NUM_PROC(NUM_PROC), .PID_W(PID_W)) u_busca (
    .ready (ready_v),
    .start (cur_pid + PID_W'(1)),
    .found (found),
    .pid   (found_pid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_ok) state_nxt = RUN;
      RUN:     if (proc_end || io_block || expire) state_nxt = SELECT;
      SELECT: begin
        if (found)           state_nxt = (found_pid == cur_pid) ? RUN : REQ;
        else if (|blocked_v) state_nxt = WAIT_IO;
        else                 state_nxt = IDLE;
      end
      REQ:     if (switch_ack) state_nxt = RUN;
      // A wake that raced with the SELECT edge leaves a READY entry behind;
      // re-select on it too so WAIT_IO cannot stall on an already-woken process.
      WAIT_IO: if (io_wake || (|ready_v)) state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PROC; i++) tbl[i] <= EMPTY;
      cnt        <= '0;
      cur_pid    <= '0;
      next_pid   <= '0;
      switch_req <= 1'b0;
      waiting_io <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      // Wake first so a same-cycle io_block on the same entry overrides it.
      if (io_wake) tbl[io_done_pid] <= READY;
      case (state)
        IDLE: begin
          if (cfg_ok) begin
            for (int i = 0; i < NUM_PROC; i++)
              tbl[i] <= (i < int'(cfg_count)) ? READY : EMPTY;
            cur_pid  <= '0;
            cnt      <= '0;
            all_done <= 1'b0;
          end
        end
        RUN: begin
          if (proc_end)          tbl[cur_pid] <= DONE;
          else if (io_block)     tbl[cur_pid] <= BLOCKED;
          else if (instr_retire) cnt <= expire ? '0 : cnt + CW'(1);
        end
        SELECT: begin
          if (found) begin
            if (found_pid == cur_pid) begin
              cnt <= '0;
            end else begin
              next_pid   <= found_pid;
              switch_req <= 1'b1;
            end
          end else if (|blocked_v) begin
            waiting_io <= 1'b1;
          end else begin
            all_done <= 1'b1;
          end
        end
        REQ: begin
          if (switch_ack) begin
            cur_pid    <= next_pid;
            switch_req <= 1'b0;
            cnt        <= '0;
          end
        end
        WAIT_IO: if (io_wake || (|ready_v)) waiting_io <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_escalonador_round_robin.sv
// Directed bench for the round-robin scheduler; expected switch targets are
// queued when each triggering event is driven and popped on each switch_req.
module tb_escalonador_round_robin;
  localparam int NP = 8;
  localparam int PW = 3;
  localparam int Q  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [PW:0]   cfg_count = '0;
  logic          instr_retire = 1'b0, proc_end = 1'b0, io_block = 1'b0;
  logic          io_done = 1'b0;
  logic [PW-1:0] io_done_pid = '0;
  logic          switch_ack = 1'b0;
  logic          switch_req, waiting_io, all_done, busy;
  logic [PW-1:0] next_pid, cur_pid;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  escalonador_round_robin #(.NUM_PROC(NP), .PID_W(PW), .QUANTUM(Q)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_count(cfg_count),
    .instr_retire(instr_retire), .proc_end(proc_end), .io_block(io_block),
    .io_done(io_done), .io_done_pid(io_done_pid), .switch_ack(switch_ack),
    .switch_req(switch_req), .next_pid(next_pid), .cur_pid(cur_pid),
    .waiting_io(waiting_io), .all_done(all_done), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    cfg_valid = 1'b0; instr_retire = 1'b0; proc_end = 1'b0; io_block = 1'b0;
    io_done = 1'b0; switch_ack = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic cfg(input int n);
    cfg_count = n[PW:0];
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_end;
    proc_end = 1'b1; tick; proc_end = 1'b0;
  endtask

  task automatic pulse_block;
    io_block = 1'b1; tick; io_block = 1'b0;
  endtask

  task automatic wait_req(input int exp_lat);
    int k = 0;
    int e;
    while (!switch_req && k < 20) begin
      tick;
      k++;
    end
    if (!switch_req) chk("req_timeout", 0, 1);
    else begin
      chk("req_latency", k, exp_lat);
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("next_pid", int'(next_pid), e);
      end
    end
  endtask

  task automatic ack_after(input int hold);
    int p = int'(next_pid);
    repeat (hold) begin
      tick;
      chk("pid_hold", int'(next_pid), p);
      chk("req_hold", int'(switch_req), 1);
    end
    switch_ack = 1'b1;
    tick;
    switch_ack = 1'b0;
    chk("cur_after_ack", int'(cur_pid), p);
    chk("req_after_ack", int'(switch_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick;
    chk("rst_req", int'(switch_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cur", int'(cur_pid), 0);
    chk("rst_next", int'(next_pid), 0);
    chk("rst_wait", int'(waiting_io), 0);
    chk("rst_done", int'(all_done), 0);
    do_reset;

    // 1: three processes, continuous retire, quantum rotation 1,2,0,1
    instr_retire = 1'b1;
    cfg(3);
    chk("t1_busy", int'(busy), 1);
    chk("t1_cur0", int'(cur_pid), 0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1);
    for (int s = 0; s < 4; s++) begin
      wait_req(Q + 1);
      ack_after(2);
    end
    chk("t1_sb_drained", exp_q.size(), 0);

    // 2: single process never switches
    do_reset;
    instr_retire = 1'b1;
    cfg(1);
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("t2_no_req", int'(switch_req), 0);
      chk("t2_cur", int'(cur_pid), 0);
    end
    instr_retire = 1'b0;
    chk("t2_busy", int'(busy), 1);

    // 3: proc_end walk to all_done
    do_reset;
    cfg(3);
    pulse_end; exp_q.push_back(1); wait_req(1); ack_after(0);
    pulse_end; exp_q.push_back(2); wait_req(1); ack_after(0);
    pulse_end;
    chk("t3_done_pending", int'(all_done), 0);
    tick;
    chk("t3_all_done", int'(all_done), 1);
    chk("t3_idle", int'(busy), 0);
    chk("t3_no_req", int'(switch_req), 0);
    tick; tick;
    chk("t3_sticky", int'(all_done), 1);
    cfg(2);
    chk("t3_cfg_clears", int'(all_done), 0);
    chk("t3_cfg_busy", int'(busy), 1);

    // 4: block both, wait, wake the former owner, then a real switch
    do_reset;
    cfg(2);
    pulse_block; exp_q.push_back(1); wait_req(1); ack_after(1);
    pulse_block;
    tick;
    chk("t4_waiting", int'(waiting_io), 1);
    chk("t4_no_req", int'(switch_req), 0);
    tick; tick;
    chk("t4_still_wait", int'(waiting_io), 1);
    io_done = 1'b1; io_done_pid = 3'd1;
    tick;
    io_done = 1'b0;
    chk("t4_wait_clr", int'(waiting_io), 0);
    tick;
    chk("t4_resume_same", int'(switch_req), 0);
    chk("t4_cur1", int'(cur_pid), 1);
    tick;
    chk("t4_no_req2", int'(switch_req), 0);
    io_done = 1'b1; io_done_pid = 3'd0;
    tick;
    io_done = 1'b0;
    pulse_block; exp_q.push_back(0); wait_req(1); ack_after(0);

    // 5a: same-cycle io_block and io_done on the owner: block wins
    do_reset;
    cfg(2);
    io_block = 1'b1; io_done = 1'b1; io_done_pid = 3'd0;
    tick;
    io_block = 1'b0; io_done = 1'b0;
    exp_q.push_back(1); wait_req(1); ack_after(0);
    pulse_block;
    tick;
    chk("t5_blk_wins", int'(waiting_io), 1);
    chk("t5_no_req", int'(switch_req), 0);

    // 5b: proc_end together with quantum expiry marks DONE
    do_reset;
    cfg(2);
    instr_retire = 1'b1;
    tick; tick; tick;
    proc_end = 1'b1;
    tick;
    proc_end = 1'b0; instr_retire = 1'b0;
    exp_q.push_back(1); wait_req(1); ack_after(0);
    pulse_end;
    tick;
    chk("t5_end_wins", int'(all_done), 1);
    chk("t5_idle", int'(busy), 0);

    // 6: async reset mid-handshake, out-of-range cfg
    do_reset;
    cfg(2);
    pulse_block; exp_q.push_back(1); wait_req(1);
    #2 reset = 1'b1;
    #1;
    chk("t6_req_drop", int'(switch_req), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_next", int'(next_pid), 0);
    tick;
    reset = 1'b0;
    tick;
    cfg(0);
    chk("t6_cfg0", int'(busy), 0);
    cfg(9);
    chk("t6_cfg9", int'(busy), 0);
    cfg(8);
    chk("t6_cfg8", int'(busy), 1);
    pulse_end; exp_q.push_back(1); wait_req(1); ack_after(0);
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
